isa_burst_server: RTL and testbench
===================================

Name: isa_burst_server

Overview:
- DDR-side responder for the instruction-fetch read channel.
- Accepts one instruction-burst request from the instruction cache: request level, byte address and length in instructions.
- Fetches the words from the DDR native read port, splitting the request into DDR bursts of at most DDR_BURST_MAX beats.
- Streams each instruction back with a valid strobe and a running delivered-count.
- Sits between the instruction cache and the DDR controller, beside the data-side read servers.

Parameters:
- ISA_WIDTH, 30, instruction width returned to the cache.
- DDR_ADDR_WIDTH, 28, byte address width on both sides.
- DDR_DATA_WIDTH, 64, DDR read data width; one instruction per beat.
- DDR_BURST_MAX, 64, maximum beats per DDR read burst.
- LEN_WIDTH, 10, width of the length and count fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ISA_read_req  in  1  level request from the cache; held until the count reaches the length.
- ISA_read_addr  in  DDR_ADDR_WIDTH  byte address of the first instruction; 8 bytes per instruction.
- isa_read_len  in  LEN_WIDTH  number of instructions requested.
- instruction_to_cache  out  ISA_WIDTH  returned instruction.
- rd_cnt_isa  out  LEN_WIDTH  instructions delivered in the current request.
- rd_burst_data_valid  out  1  beat strobe.
- ddr_rd_req  out  1  DDR burst request; held until ack.
- ddr_rd_ack  in  1  one-cycle acceptance of ddr_rd_req.
- ddr_rd_addr  out  DDR_ADDR_WIDTH  DDR burst byte address.
- ddr_rd_len  out  LEN_WIDTH  DDR burst length in beats, 1..DDR_BURST_MAX.
- ddr_rd_data_valid  in  1  DDR beat valid.
- ddr_rd_data  in  DDR_DATA_WIDTH  DDR beat data.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Applies on any clk edge with rst=1, including mid-burst; DDR beats arriving afterwards are ignored.
- Latching (IDLE, ISA_read_req=1): latch addr with low 3 bits forced to 0, and latch len.
  - len=0: go to HOLD.
  - otherwise: remaining=len, go to ISSUE.
- ISSUE: ddr_rd_req=1, ddr_rd_addr=cur_addr, ddr_rd_len=min(remaining, DDR_BURST_MAX).
  - Outputs stay stable until ddr_rd_ack.
  - On ack: drop req, load beat_left=ddr_rd_len, go to STREAM.
- STREAM: each ddr_rd_data_valid with beat_left>0 is one beat k (0-based within the request).
  - Cycle t: rd_burst_data_valid=1.
  - Cycle t+1: instruction_to_cache = ddr_rd_data[ISA_WIDTH-1:0] of that beat, rd_cnt_isa=k+1.
  - Valid leads data/count by exactly one cycle so the cache's delayed-valid write lands correctly.
  - Back-to-back beats are supported at 1 per cycle.
  - instruction_to_cache and rd_cnt_isa hold between beats.
- Burst end (beat_left reaches 0):
  - cur_addr += burst_len<<3; remaining -= burst_len.
  - remaining>0: go to ISSUE.
  - otherwise: go to HOLD.
- Extra DDR beats: ddr_rd_data_valid while beat_left=0 or outside STREAM is ignored.
- HOLD: rd_cnt_isa holds the final value (=len) until ISA_read_req=0.
  - Then rd_cnt_isa and instruction_to_cache keep their values one more cycle.
  - rd_cnt_isa clears to 0 on entry to IDLE.
  - A new request is accepted no earlier than the cycle after IDLE is entered.
- Request dropped early (ISA_read_req=0 in ISSUE or STREAM), i.e. an abort:
  - In ISSUE before ack: drop ddr_rd_req and go to IDLE.
  - After ack: go to DRAIN, consume the remaining beat_left beats with rd_burst_data_valid held 0, then go to IDLE.
  - rd_cnt_isa clears on IDLE entry.
- Address arithmetic wraps modulo 2^DDR_ADDR_WIDTH. No request splitting at any DDR page boundary.
- Changes to ISA_read_addr or isa_read_len while the request is active are ignored.
- rd_cnt_isa never exceeds the latched len.

Test Plan:
- Basic burst: addr=0x000, len=4, DDR returns beats D0..D3 back-to-back two cycles after ack.
  - Required: valid on 4 consecutive cycles; next cycles show (D0,1), (D1,2), (D2,3), (D3,4).
  - Required: count holds 4 until req drops, then 0.
- Split: addr=0x400, len=128, DDR_BURST_MAX=64.
  - Required: two DDR requests, (0x400, 64) then (0x600, 64).
  - Required: rd_cnt_isa runs 1..128 continuously across the burst boundary.
- Gapped beats: len=3, DDR valid on cycles t, t+3, t+4.
  - Required: rd_burst_data_valid on the same cycles; data/count update at t+1, t+4, t+5; values hold in between.
- Zero length and misalignment:
  - len=0: no DDR request; rd_cnt_isa=0 until req drops.
  - addr=0x10F, len=1: ddr_rd_addr=0x108.
- Abort: req drops after 2 of 8 beats.
  - Required: the remaining 6 DDR beats are consumed with no rd_burst_data_valid.
  - Required: IDLE, then a new request (addr=0x800, len=2) is served correctly.
- Reset mid-STREAM: rst=1 for one cycle.
  - Required: all outputs 0 next cycle; stray DDR beats ignored; next request served normally.

Source files
------------

// File: rtl/isa_burst_server_if.sv
// Bundle of the instruction-fetch request/return signals and the DDR native
// read-port signals seen by isa_burst_server. The slave modport is the server's
// view. The master modport is the view of the environment, which is the cache
// plus the DDR controller.
interface isa_burst_server_if #(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int LEN_WIDTH      = 10
) ();
  // cache side
  logic                      ISA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
  logic [LEN_WIDTH-1:0]      isa_read_len;
  logic [ISA_WIDTH-1:0]      instruction_to_cache;
  logic [LEN_WIDTH-1:0]      rd_cnt_isa;
  logic                      rd_burst_data_valid;
  // DDR side
  logic                      ddr_rd_req;
  logic                      ddr_rd_ack;
  logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
  logic [LEN_WIDTH-1:0]      ddr_rd_len;
  logic                      ddr_rd_data_valid;
  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data;

  modport slave (
    input  ISA_read_req, ISA_read_addr, isa_read_len,
    output instruction_to_cache, rd_cnt_isa, rd_burst_data_valid,
    output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    input  ddr_rd_ack, ddr_rd_data_valid, ddr_rd_data
  );

  modport master (
    output ISA_read_req, ISA_read_addr, isa_read_len,
    input  instruction_to_cache, rd_cnt_isa, rd_burst_data_valid,
    input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    output ddr_rd_ack, ddr_rd_data_valid, ddr_rd_data
  );
endinterface

// File: rtl/isa_burst_server.sv
// Instruction-fetch read server. It takes one burst request from the
// instruction cache and splits it into DDR reads of at most DDR_BURST_MAX
// beats. Each returned beat is streamed back as one instruction. The valid
// strobe comes one cycle ahead of the data and the running count.
module isa_burst_server #(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int DDR_BURST_MAX  = 64,
  parameter int LEN_WIDTH      = 10
) (
  input  logic                clk,
  input  logic                rst,
  isa_burst_server_if.slave   bus
);

  localparam logic [LEN_WIDTH-1:0] BURST_MAX_L = LEN_WIDTH'(DDR_BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DRAIN,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t                    state_q;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr_q;   // doubles as the current burst address
  logic [LEN_WIDTH-1:0]      ddr_len_q;    // length of the current burst
  logic                      ddr_req_q;
  logic [LEN_WIDTH-1:0]      rem_q;        // instructions not yet requested from DDR
  logic [LEN_WIDTH-1:0]      beat_left_q;  // beats still owed by the acked burst
  logic [LEN_WIDTH-1:0]      cnt_q;
  logic [ISA_WIDTH-1:0]      instr_q;

  logic [DDR_ADDR_WIDTH-1:0] addr_next_d;
  logic [LEN_WIDTH-1:0]      rem_next_d;
  logic [LEN_WIDTH-1:0]      burst_len_d;
  logic [LEN_WIDTH-1:0]      first_len_d;
  logic                      beat_take;
  logic                      unused_data_bits;

  // Only the low ISA_WIDTH bits of a DDR beat carry the instruction.
  assign unused_data_bits = &{1'b0, bus.ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH]};

  // A beat goes to the cache only while streaming with the request still held.
  // When the request has been dropped, the beat is drained instead.
  assign beat_take = (state_q == S_STREAM) && bus.ddr_rd_data_valid && bus.ISA_read_req;

  // Address and length of the burst that follows the current one. This is
  // evaluated while the last beat of the current burst is being taken.
  always_comb begin
    addr_next_d = ddr_addr_q + DDR_ADDR_WIDTH'({ddr_len_q, 3'b000});
    rem_next_d  = rem_q - ddr_len_q;
    burst_len_d = (rem_next_d > BURST_MAX_L) ? BURST_MAX_L : rem_next_d;
    first_len_d = (bus.isa_read_len > BURST_MAX_L) ? BURST_MAX_L : bus.isa_read_len;
  end

  // Request/burst sequencer. It also registers every output except the valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ddr_addr_q  <= '0;
      ddr_len_q   <= '0;
      ddr_req_q   <= 1'b0;
      rem_q       <= '0;
      beat_left_q <= '0;
      cnt_q       <= '0;
      instr_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ISA_read_req) begin
            ddr_addr_q <= {bus.ISA_read_addr[DDR_ADDR_WIDTH-1:3], 3'b000};
            rem_q      <= bus.isa_read_len;
            if (bus.isa_read_len == '0) begin
              state_q <= S_HOLD;
            end else begin
              ddr_len_q <= first_len_d;
              ddr_req_q <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (bus.ddr_rd_ack) begin
            // Once a burst is accepted, its beats must be absorbed, even on abort.
            ddr_req_q   <= 1'b0;
            beat_left_q <= ddr_len_q;
            state_q     <= bus.ISA_read_req ? S_STREAM : S_DRAIN;
          end else if (!bus.ISA_read_req) begin
            ddr_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
          end
        end

        S_STREAM: begin
          if (!bus.ISA_read_req) begin
            if (bus.ddr_rd_data_valid) begin
              beat_left_q <= beat_left_q - 1'b1;
              if (beat_left_q == LEN_WIDTH'(1)) begin
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (bus.ddr_rd_data_valid) begin
            instr_q     <= bus.ddr_rd_data[ISA_WIDTH-1:0];
            cnt_q       <= cnt_q + 1'b1;
            beat_left_q <= beat_left_q - 1'b1;
            if (beat_left_q == LEN_WIDTH'(1)) begin
              ddr_addr_q <= addr_next_d;
              rem_q      <= rem_next_d;
              if (rem_next_d != '0) begin
                ddr_len_q <= burst_len_d;
                ddr_req_q <= 1'b1;
                state_q   <= S_ISSUE;
              end else begin
                state_q <= S_HOLD;
              end
            end
          end
        end

        S_DRAIN: begin
          if (bus.ddr_rd_data_valid) begin
            beat_left_q <= beat_left_q - 1'b1;
            if (beat_left_q == LEN_WIDTH'(1)) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
        end

        S_HOLD: begin
          if (!bus.ISA_read_req) begin
            state_q <= S_RELEASE;
          end
        end

        // The final count stays visible for one cycle after the request drops.
        S_RELEASE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instruction_to_cache = instr_q;
  assign bus.rd_cnt_isa           = cnt_q;
  assign bus.rd_burst_data_valid  = beat_take;
  assign bus.ddr_rd_req           = ddr_req_q;
  assign bus.ddr_rd_addr          = ddr_addr_q;
  assign bus.ddr_rd_len           = ddr_len_q;

endmodule

// File: tb/tb_isa_burst_server.sv
// Self-checking bench for isa_burst_server. Directed scenarios are followed by
// randomized requests. Expected DDR bursts and returned instructions come from a
// transaction-level model of the request-splitting rules.
module tb_isa_burst_server;

  localparam int IW = 30;
  localparam int AW = 28;
  localparam int DW = 64;
  localparam int BM = 64;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isa_burst_server_if #(.ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  isa_burst_server #(
    .ISA_WIDTH(IW), .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .DDR_BURST_MAX(BM), .LEN_WIDTH(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          exp_cnt   = 0;
  logic [IW-1:0] exp_instr = '0;
  int          fixed_gaps[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle with no legitimate beat. A stray beat may be offered.
  task automatic idle_cycle(input logic stray);
    bus.ddr_rd_data_valid = stray;
    bus.ddr_rd_data = {$urandom, $urandom};
    #1 check("no_valid", 64'(bus.rd_burst_data_valid), 64'd0);
    @(negedge clk);
    bus.ddr_rd_data_valid = 1'b0;
    check("instr_hold", 64'(bus.instruction_to_cache), 64'(exp_instr));
    check("cnt_hold", 64'(bus.rd_cnt_isa), 64'(exp_cnt));
  endtask

  // One legitimate beat. The strobe is expected in the same cycle, and the data and count in the next.
  task automatic drive_beat();
    logic [63:0] d;
    d = {$urandom, $urandom};
    bus.ddr_rd_data_valid = 1'b1;
    bus.ddr_rd_data = d;
    #1 check("beat_valid", 64'(bus.rd_burst_data_valid), 64'd1);
    @(negedge clk);
    bus.ddr_rd_data_valid = 1'b0;
    exp_cnt++;
    exp_instr = d[IW-1:0];
    check("beat_instr", 64'(bus.instruction_to_cache), 64'(exp_instr));
    check("beat_cnt", 64'(bus.rd_cnt_isa), 64'(exp_cnt));
  endtask

  task automatic wait_ddr_req(output bit ok);
    int w;
    w = 0;
    while (bus.ddr_rd_req !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("ddr_req_seen", 64'(bus.ddr_rd_req), 64'd1);
    ok = (bus.ddr_rd_req === 1'b1);
  endtask

  task automatic do_ack();
    bus.ddr_rd_ack = 1'b1;
    @(negedge clk);
    bus.ddr_rd_ack = 1'b0;
    check("ddr_req_drop_on_ack", 64'(bus.ddr_rd_req), 64'd0);
  endtask

  // Full request: the bench models the burst split, acks each DDR burst, returns beats,
  // optionally aborts after abort_after beats, and then releases the request.
  task automatic serve(input logic [AW-1:0] a, input int len, input int gap_max, input int abort_after);
    logic [AW-1:0] ba[$];
    int            bl[$];
    logic [AW-1:0] cur;
    int            rem, l, k, gap, left;
    bit            ok, aborted;
    cur = {a[AW-1:3], 3'b000};
    rem = len;
    while (rem > 0) begin
      l = (rem > BM) ? BM : rem;
      ba.push_back(cur);
      bl.push_back(l);
      cur = cur + AW'(l * 8);
      rem -= l;
    end
    bus.ddr_rd_data_valid = 1'b0;
    bus.ISA_read_req  = 1'b1;
    bus.ISA_read_addr = a;
    bus.isa_read_len  = LW'(len);
    k = 0;
    aborted = 0;
    if (len == 0) begin
      repeat (4) begin
        @(negedge clk);
        check("zero_no_ddr_req", 64'(bus.ddr_rd_req), 64'd0);
        check("zero_cnt", 64'(bus.rd_cnt_isa), 64'd0);
      end
    end
    for (int b = 0; b < ba.size() && !aborted; b++) begin
      wait_ddr_req(ok);
      if (!ok) return;
      check("ddr_addr", 64'(bus.ddr_rd_addr), 64'(ba[b]));
      check("ddr_len", 64'(bus.ddr_rd_len), 64'(bl[b]));
      // Changes to address and length after acceptance must have no effect.
      bus.ISA_read_addr = AW'($urandom);
      bus.isa_read_len  = LW'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("ddr_req_stable", 64'(bus.ddr_rd_req), 64'd1);
        check("ddr_addr_stable", 64'(bus.ddr_rd_addr), 64'(ba[b]));
      end
      do_ack();
      repeat (1 + $urandom_range(0, gap_max)) idle_cycle(1'b0);
      for (int j = 0; j < bl[b]; j++) begin
        if (abort_after > 0 && k == abort_after) begin
          left = bl[b] - j;
          bus.ISA_read_req = 1'b0;
          idle_cycle(1'b0);
          for (int i = 0; i < left; i++) begin
            bus.ddr_rd_data_valid = 1'b1;
            bus.ddr_rd_data = {$urandom, $urandom};
            #1 check("drain_no_valid", 64'(bus.rd_burst_data_valid), 64'd0);
            @(negedge clk);
            bus.ddr_rd_data_valid = 1'b0;
            if (i == left - 1) exp_cnt = 0;
            check("drain_cnt", 64'(bus.rd_cnt_isa), 64'(exp_cnt));
            check("drain_instr", 64'(bus.instruction_to_cache), 64'(exp_instr));
          end
          idle_cycle(1'b1);
          check("abort_no_ddr_req", 64'(bus.ddr_rd_req), 64'd0);
          aborted = 1;
          break;
        end
        gap = (fixed_gaps.size() > k) ? fixed_gaps[k] : ((j == 0) ? 0 : int'($urandom_range(0, gap_max)));
        repeat (gap) idle_cycle(1'b0);
        drive_beat();
        k++;
      end
    end
    if (!aborted) begin
      check("hold_cnt_len", 64'(bus.rd_cnt_isa), 64'(len));
      repeat ($urandom_range(1, 3)) begin
        idle_cycle(1'($urandom_range(0, 1)));
        check("hold_no_ddr_req", 64'(bus.ddr_rd_req), 64'd0);
      end
      bus.ISA_read_req = 1'b0;
      @(negedge clk);
      check("cnt_after_drop", 64'(bus.rd_cnt_isa), 64'(len));
      @(negedge clk);
      exp_cnt = 0;
      check("cnt_idle_clear", 64'(bus.rd_cnt_isa), 64'd0);
      check("instr_idle_hold", 64'(bus.instruction_to_cache), 64'(exp_instr));
    end
  endtask

  initial begin
    bit ok;
    bus.ISA_read_req      = 1'b0;
    bus.ISA_read_addr     = '0;
    bus.isa_read_len      = '0;
    bus.ddr_rd_ack        = 1'b0;
    bus.ddr_rd_data_valid = 1'b0;
    bus.ddr_rd_data       = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_instr", 64'(bus.instruction_to_cache), 64'd0);
    check("rst_cnt", 64'(bus.rd_cnt_isa), 64'd0);
    check("rst_valid", 64'(bus.rd_burst_data_valid), 64'd0);
    check("rst_ddr_req", 64'(bus.ddr_rd_req), 64'd0);
    check("rst_ddr_addr", 64'(bus.ddr_rd_addr), 64'd0);
    check("rst_ddr_len", 64'(bus.ddr_rd_len), 64'd0);
    rst = 1'b0;

    // basic back-to-back burst
    serve(28'h000, 4, 0, 0);
    // split into two DDR bursts
    serve(28'h400, 128, 0, 0);
    // gapped beats: t, t+3, t+4
    fixed_gaps = '{0, 2, 0};
    serve(28'h100, 3, 0, 0);
    fixed_gaps.delete();
    // zero length and misaligned address
    serve(28'h040, 0, 0, 0);
    serve(28'h10F, 1, 1, 0);
    // abort after 2 of 8 beats, then a fresh request
    serve(28'h200, 8, 0, 2);
    serve(28'h800, 2, 0, 0);

    // abort while the DDR request is still pending
    bus.ISA_read_req  = 1'b1;
    bus.ISA_read_addr = 28'h300;
    bus.isa_read_len  = 10'd5;
    wait_ddr_req(ok);
    check("issue_abort_addr", 64'(bus.ddr_rd_addr), 64'h300);
    bus.ISA_read_req = 1'b0;
    @(negedge clk);
    check("issue_abort_req_drop", 64'(bus.ddr_rd_req), 64'd0);
    check("issue_abort_cnt", 64'(bus.rd_cnt_isa), 64'd0);
    idle_cycle(1'b1);

    // reset in the middle of a stream
    bus.ISA_read_req  = 1'b1;
    bus.ISA_read_addr = 28'hA00;
    bus.isa_read_len  = 10'd8;
    wait_ddr_req(ok);
    do_ack();
    idle_cycle(1'b0);
    repeat (3) drive_beat();
    rst = 1'b1;
    bus.ISA_read_req = 1'b0;
    bus.ddr_rd_data_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_instr = '0;
    check("mid_rst_instr", 64'(bus.instruction_to_cache), 64'd0);
    check("mid_rst_cnt", 64'(bus.rd_cnt_isa), 64'd0);
    check("mid_rst_ddr_req", 64'(bus.ddr_rd_req), 64'd0);
    check("mid_rst_ddr_addr", 64'(bus.ddr_rd_addr), 64'd0);
    check("mid_rst_ddr_len", 64'(bus.ddr_rd_len), 64'd0);
    repeat (3) idle_cycle(1'b1);
    serve(28'h1000, 5, 1, 0);

    // address wrap across the top of the address space
    serve(28'hFFFFFF0, 70, 1, 0);

    // randomized requests
    for (int r = 0; r < 8; r++) begin
      serve(AW'($urandom), int'($urandom_range(1, 200)), 2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
